// File: rtl/de_issue_buffer.sv
// Decode/issue stage: decodes fetched instructions into register indices,
// opcode class and sign-extended immediate, queues them in a DEPTH-entry
// FIFO, inserts the load-use bubble, and counts hazard stall cycles.
module de_issue_buffer #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_ir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_func3,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [XLEN-1:0]            out_immed,
  output logic                       out_mem_read,
  output logic                       out_mem_write,
  output logic                       out_reg_write,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           hazard_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // One decoded instruction as held in the buffer.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] immed;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            rs1_used;
    logic            rs2_used;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           dec;
  entry_t           head;
  logic [31:0]      imm32;
  logic [6:0]       op;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [4:0]       ld_rd;
  logic [CNT_W-1:0] cnt;
  logic             head_valid;
  logic             hazard;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign op = in_ir[6:0];

  // Decode the offered instruction into the bundle written at the tail.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    imm32 = '0;
    dec   = '0;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
      OP_STORE:                 imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
      OP_BRANCH:                imm32 = {{20{in_ir[31]}}, in_ir[7], in_ir[30:25],
                                         in_ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {in_ir[31:12], 12'b0};
      OP_JAL:                   imm32 = {{12{in_ir[31]}}, in_ir[19:12], in_ir[20],
                                         in_ir[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
    dec.pc        = in_pc;
    dec.opcode    = op;
    dec.func3     = in_ir[14:12];
    dec.rd        = in_ir[11:7];
    dec.rs1       = in_ir[19:15];
    dec.rs2       = in_ir[24:20];
    dec.immed     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    dec.mem_read  = (op == OP_LOAD);
    dec.mem_write = (op == OP_STORE);
    dec.reg_write = (op != OP_STORE) && (op != OP_BRANCH) && (in_ir[11:7] != 5'd0);
    dec.rs1_used  = (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    dec.rs2_used  = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (occ != '0);
  // A load still in EX whose rd the head reads forces a bubble; x0 never matches
  // because ld_rd==0 means "no pending load".
  assign hazard     = head_valid && (ld_rd != 5'd0) &&
                      ((head.rs1_used && (head.rs1 == ld_rd)) ||
                       (head.rs2_used && (head.rs2 == ld_rd)));
  assign in_ready   = (occ < FULL_OCC) && !flush;
  assign out_valid  = head_valid && !hazard && !flush;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  // Entry storage: written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage is reset too, so the out_* data fields read as zero
    // straight out of reset instead of showing stale or unknown contents.
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Pointers, occupancy and the in-flight load tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ld_rd  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ld_rd  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
      if (pop) begin
        ld_rd <= head.mem_read ? head.rd : 5'd0;
      end else if (out_ready) begin
        ld_rd <= '0;
      end
    end
  end

  // Saturating count of cycles EX was ready but received a load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hazard && out_ready && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_pc        = head.pc;
  assign out_opcode    = head.opcode;
  assign out_func3     = head.func3;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_immed     = head.immed;
  assign out_mem_read  = head.mem_read;
  assign out_mem_write = head.mem_write;
  assign out_reg_write = head.reg_write;
  assign occupancy     = occ;
  assign hazard_cnt    = cnt;

endmodule

// File: doc/de_issue_buffer.md
# de_issue_buffer

Parametrised decode/issue stage for the pipelined RISC-V core. Accepts fetched instructions over a valid/ready handshake and decodes register indices, opcode class and the sign-extended immediate. It buffers the results in a DEPTH-entry FIFO and issues them to EX. It also enforces the load-use bubble internally, supports a synchronous pipeline flush, and keeps a saturating hazard-stall counter.

## Interface
- XLEN, 32: immediate/data width (32 or 64); immediates sign-extend to XLEN.
- PC_W, 32: PC width.
- DEPTH, 2: buffer entries, power of two, ≥1.
- CNT_W, 16: hazard counter width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush (branch/jump/trap redirect).
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  buffer can accept this cycle.
- in_pc  in  PC_W  instruction PC.
- in_ir  in  32  instruction word.
- out_valid  out  1  head entry issuable.
- out_ready  in  1  EX accepts this cycle.
- out_pc  out  PC_W  PC of the head entry.
- out_opcode  out  7  ir[6:0].
- out_func3  out  3  ir[14:12].
- out_rd / out_rs1 / out_rs2  out  5 each  ir[11:7] / ir[19:15] / ir[24:20].
- out_immed  out  XLEN  sign-extended immediate.
- out_mem_read  out  1  opcode is LOAD (0000011).
- out_mem_write  out  1  opcode is STORE (0100011).
- out_reg_write  out  1  rd is written (not STORE/BRANCH) and rd≠0.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- hazard_cnt  out  CNT_W  saturating count of load-use bubble cycles.

## Operation
- Push: when in_valid && in_ready, the decoded bundle is written at the tail. Immediates are computed at push:
  - I-type (LOAD, OP-IMM 0010011, JALR 1100111): ir[31:20].
  - S-type: {ir[31:25],ir[11:7]}.
  - B-type: {ir[31],ir[7],ir[30:25],ir[11:8],0}.
  - U-type (LUI 0110111, AUIPC 0010111): {ir[31:12],12'b0}.
  - J-type: {ir[31],ir[19:12],ir[20],ir[30:21],0}.
  - All other opcodes: 0.
  - All immediates sign-extend from bit 31 of the assembled value to XLEN.
- in_ready = (occupancy < DEPTH) && !flush. There is no combinational path from out_ready to in_ready, so a full buffer with a simultaneous pop still refuses the push.
- Pop: the head is removed when out_valid && out_ready.
- Operand use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by OP (0110011), STORE and BRANCH.
- Load tracker ld_rd (5 bits):
  - On a pop, ld_rd takes out_rd if out_mem_read, otherwise 0.
  - On a cycle with out_ready=1 and no pop (a bubble enters EX), ld_rd clears to 0.
  - On out_ready=0, ld_rd holds.
- hazard = head valid && ld_rd≠0 && ((rs1 used && rs1==ld_rd) || (rs2 used && rs2==ld_rd)).
- out_valid = (occupancy>0) && !hazard && !flush.
- hazard_cnt increments on each cycle with hazard && out_ready. It saturates at all-ones.
- Flush: at the edge, occupancy goes to 0, pointers reset and ld_rd clears. Any push offered that cycle is dropped. hazard_cnt is unaffected.
- rd=x0 never creates a hazard.

## Timing
- Reset (rst_n low, async): occupancy=0, pointers=0, ld_rd=0, hazard_cnt=0. Consequently out_valid=0 and in_ready=1 once flush is low. out_* data fields are 0.
- Latency: an instruction pushed at edge N is visible on out_* in cycle N+1, issuable unless there is a hazard.
- Throughput: one push and one pop per cycle. Simultaneous push/pop while not full leaves occupancy unchanged.
- Load followed by a dependent instruction: exactly one bubble cycle (out_valid=0 with out_ready=1), then issue.
- The pointers wrap modulo DEPTH. With DEPTH=1 the buffer alternates between full and empty, and in_ready drops in every cycle it holds an entry.
- Reset asserted mid-operation discards all entries immediately. The first edge after release accepts a push.
- Flush and push in the same cycle: the flush wins. Flush and pop in the same cycle: the pop does not occur (out_valid=0).

## Test plan
- Reset, then push ADDI x1,x0,-5 (0xFFB00093) at PC 0x100 → next cycle out_valid=1, out_rd=1, out_rs1=0, out_immed=0xFFFFFFFB, out_reg_write=1.
- Issue LW x5,0(x2), then ADD x6,x5,x7, with out_ready=1 throughout → one bubble cycle, ADD issues two cycles after LW, hazard_cnt=1.
- Issue LW x5, then LUI x5 → no bubble, because LUI does not use rs1/rs2.
- DEPTH=2, hold out_ready=0 and push 3 instructions → in_ready=0 after 2 pushes, occupancy=2. Release out_ready → FIFO order preserved, wrap exercised.
- Buffer holding 2 entries, assert flush with in_valid=1 → next cycle occupancy=0, out_valid=0, the pushed instruction is absent.
- Preload hazard_cnt near saturation with CNT_W=2 → holds at 3 through further hazards. Async reset mid-stream clears it to 0 without waiting for a clock edge.
